// File: rtl/fft_frame_unpacker_pkg.sv
// fft_frame_unpacker_pkg
// Shared definitions for the FFT frame unpacker: frame geometry, the sample
// type, the beat-phase and drain-state encodings and the 4-bit bit-reversal
// helper used to emit bins in FFT-native order.
package fft_frame_unpacker_pkg;

    localparam int DW    = 16;
    localparam int N     = 16;
    localparam int LANES = N;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic {RE = 1'b0, IM = 1'b1} beat_phase_t;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} drain_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank
// Two-bank frame store: each bank holds N real and N imaginary samples.
// A whole 16-lane beat is written at once into the selected bank and half
// (real or imaginary); a single combinational read port returns one complex
// sample from any bank/index.
//
// Ports:
//   clk       in   clock, rising edge
//   wr_en     in   write the lanes this cycle
//   wr_bank   in   bank to write
//   wr_im     in   0 = real half, 1 = imaginary half
//   wr_lanes  in   N samples of DW bits, lane k = bin k
//   rd_bank   in   bank to read
//   rd_idx    in   bin index to read
//   rd_re     out  real part of the addressed sample
//   rd_im     out  imaginary part of the addressed sample
module fft_frame_bank #(
    parameter int DW = fft_frame_unpacker_pkg::DW,
    parameter int N  = fft_frame_unpacker_pkg::N
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic          wr_im,
    input  logic [DW-1:0] wr_lanes [N],
    input  logic          rd_bank,
    input  logic [3:0]    rd_idx,
    output logic [DW-1:0] rd_re,
    output logic [DW-1:0] rd_im
);

    logic [DW-1:0] re_mem [2][N];
    logic [DW-1:0] im_mem [2][N];

    // Storage carries no reset: validity of a bank is tracked by the
    // full flags in the parent, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < N; k++) begin
                if (wr_im) begin
                    im_mem[wr_bank][k] <= wr_lanes[k];
                end else begin
                    re_mem[wr_bank][k] <= wr_lanes[k];
                end
            end
        end
    end

    assign rd_re = re_mem[rd_bank][rd_idx];
    assign rd_im = im_mem[rd_bank][rd_idx];

endmodule

// File: rtl/fft_frame_unpacker.sv
// fft_frame_unpacker
// Captures FFT frames (one real beat then one imaginary beat of 16 lanes)
// into a two-bank buffer and drains them as a serial complex stream over a
// valid/ready handshake. Frames arriving while the target bank is still
// occupied are dropped and flagged on the sticky overflow output.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   fft_valid           one-cycle beat, lanes valid
//   done                FFT core finished (level or pulse)
//   fft_d0..fft_d15     lane k = bin k of the current beat
//   out_valid/out_ready serial handshake
//   out_re, out_im      current complex sample
//   out_idx             bin index of the current sample
//   out_last            high with the last sample of a frame
//   out_done            all frames drained after done (sticky by nature)
//   overflow            a frame was dropped (sticky)
module fft_frame_unpacker #(
    parameter int DW     = 16,
    parameter int N      = 16,
    parameter int BITREV = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic          done,
    input  logic [DW-1:0] fft_d0,
    input  logic [DW-1:0] fft_d1,
    input  logic [DW-1:0] fft_d2,
    input  logic [DW-1:0] fft_d3,
    input  logic [DW-1:0] fft_d4,
    input  logic [DW-1:0] fft_d5,
    input  logic [DW-1:0] fft_d6,
    input  logic [DW-1:0] fft_d7,
    input  logic [DW-1:0] fft_d8,
    input  logic [DW-1:0] fft_d9,
    input  logic [DW-1:0] fft_d10,
    input  logic [DW-1:0] fft_d11,
    input  logic [DW-1:0] fft_d12,
    input  logic [DW-1:0] fft_d13,
    input  logic [DW-1:0] fft_d14,
    input  logic [DW-1:0] fft_d15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [3:0]    out_idx,
    output logic          out_last,
    output logic          out_done,
    output logic          overflow
);

    import fft_frame_unpacker_pkg::*;

    beat_phase_t   phase;
    drain_state_t  state;
    logic          wr_bank;
    logic          rd_bank;
    logic          drop;
    logic          done_seen;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic [3:0]    rd_cnt;
    logic [3:0]    rd_idx;
    logic [DW-1:0] rd_re;
    logic [DW-1:0] rd_im;
    logic [DW-1:0] lanes [N];

    logic handshake;
    logic release_bank;
    logic wr_full;
    logic re_beat;
    logic im_beat;
    logic re_drop;
    logic im_capture;
    logic bank_we;

    assign lanes = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                     fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

    assign handshake    = out_valid && out_ready;
    assign release_bank = handshake && (rd_cnt == 4'd15);

    // A bank being released this very cycle counts as free, so a real beat
    // landing on it is accepted rather than dropped.
    assign wr_full    = full[wr_bank] && !(release_bank && (rd_bank == wr_bank));
    assign re_beat    = fft_valid && (phase == RE);
    assign im_beat    = fft_valid && (phase == IM);
    assign re_drop    = re_beat && wr_full;
    assign im_capture = im_beat && !drop;
    assign bank_we    = (re_beat && !wr_full) || im_capture;

    // Next-cycle occupancy; the drain FSM looks at it so a frame completed
    // on this edge is presented on the very next cycle without a bubble.
    always_comb begin
        full_next = full;
        if (release_bank) begin
            full_next[rd_bank] = 1'b0;
        end
        if (im_capture) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    fft_frame_bank #(
        .DW(DW),
        .N (N)
    ) u_bank (
        .clk     (clk),
        .wr_en   (bank_we),
        .wr_bank (wr_bank),
        .wr_im   (phase == IM),
        .wr_lanes(lanes),
        .rd_bank (rd_bank),
        .rd_idx  (rd_idx),
        .rd_re   (rd_re),
        .rd_im   (rd_im)
    );

    // Capture side: beat phase, drop tracking, bank occupancy, done latch.
    // Drain side: IDLE/SEND FSM walking rd_cnt through the current bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= RE;
            state     <= IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            drop      <= 1'b0;
            done_seen <= 1'b0;
            full      <= 2'b00;
            rd_cnt    <= 4'd0;
            out_done  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (fft_valid) begin
                phase <= (phase == RE) ? IM : RE;
            end
            if (re_drop) begin
                drop     <= 1'b1;
                overflow <= 1'b1;
            end else if (im_beat) begin
                drop <= 1'b0;
            end
            if (im_capture) begin
                wr_bank <= ~wr_bank;
            end
            full <= full_next;
            if (done) begin
                done_seen <= 1'b1;
            end
            out_done <= done_seen && (full == 2'b00) && (phase == RE) && (state == IDLE);

            case (state)
                IDLE: begin
                    if (full_next[rd_bank]) begin
                        state  <= SEND;
                        rd_cnt <= 4'd0;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        rd_cnt <= rd_cnt + 4'd1;
                        if (rd_cnt == 4'd15) begin
                            rd_bank <= ~rd_bank;
                            if (!full_next[~rd_bank]) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rd_idx    = (BITREV != 0) ? bitrev4(rd_cnt) : rd_cnt;
    assign out_valid = (state == SEND);
    assign out_idx   = out_valid ? rd_idx : 4'd0;
    assign out_re    = out_valid ? rd_re : '0;
    assign out_im    = out_valid ? rd_im : '0;
    assign out_last  = out_valid && (rd_cnt == 4'd15);

endmodule

// File: tb/tb_fft_frame_unpacker.sv
// tb_fft_frame_unpacker
// Self-checking bench: frames are driven lane-parallel, expected serial
// samples are queued at drive time and compared as the DUT emits them.
// Two instances share the inputs: natural order (a_*) and bit-reversed (b_*).
`timescale 1ns/1ps
module tb_fft_frame_unpacker;

    localparam int DW = 16;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fft_valid;
    logic          done;
    logic          out_ready;
    logic [DW-1:0] lane [16];

    logic          a_valid, a_last, a_done, a_ovf;
    logic [DW-1:0] a_re, a_im;
    logic [3:0]    a_idx;
    logic          b_valid, b_last, b_done, b_ovf;
    logic [DW-1:0] b_re, b_im;
    logic [3:0]    b_idx;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc;

    always #5 clk = ~clk;

    fft_frame_unpacker #(.DW(DW), .N(16), .BITREV(0)) dut_a (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .done(done),
        .fft_d0(lane[0]), .fft_d1(lane[1]), .fft_d2(lane[2]), .fft_d3(lane[3]),
        .fft_d4(lane[4]), .fft_d5(lane[5]), .fft_d6(lane[6]), .fft_d7(lane[7]),
        .fft_d8(lane[8]), .fft_d9(lane[9]), .fft_d10(lane[10]), .fft_d11(lane[11]),
        .fft_d12(lane[12]), .fft_d13(lane[13]), .fft_d14(lane[14]), .fft_d15(lane[15]),
        .out_valid(a_valid), .out_ready(out_ready), .out_re(a_re), .out_im(a_im),
        .out_idx(a_idx), .out_last(a_last), .out_done(a_done), .overflow(a_ovf)
    );

    fft_frame_unpacker #(.DW(DW), .N(16), .BITREV(1)) dut_b (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .done(done),
        .fft_d0(lane[0]), .fft_d1(lane[1]), .fft_d2(lane[2]), .fft_d3(lane[3]),
        .fft_d4(lane[4]), .fft_d5(lane[5]), .fft_d6(lane[6]), .fft_d7(lane[7]),
        .fft_d8(lane[8]), .fft_d9(lane[9]), .fft_d10(lane[10]), .fft_d11(lane[11]),
        .fft_d12(lane[12]), .fft_d13(lane[13]), .fft_d14(lane[14]), .fft_d15(lane[15]),
        .out_valid(b_valid), .out_ready(out_ready), .out_re(b_re), .out_im(b_im),
        .out_idx(b_idx), .out_last(b_last), .out_done(b_done), .overflow(b_ovf)
    );

    function automatic logic [3:0] tb_rev(input int i);
        logic [3:0] v;
        v = i[3:0];
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [15:0] frame_re(input int f, input int k);
        return 16'(k * 256 + f);
    endfunction

    function automatic logic [15:0] frame_im(input int f, input int k);
        return 16'(-(k * 16) - f);
    endfunction

    // Drive one frame (real beat then imaginary beat); queue its samples in
    // the order the DUT is expected to emit them.
    task automatic send_frame(input int f, input bit push, input bit rev);
        exp_t s;
        int   k;
        for (int i = 0; i < 16; i++) lane[i] = frame_re(f, i);
        fft_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) lane[i] = frame_im(f, i);
        @(posedge clk); #1;
        fft_valid = 1'b0;
        if (push) begin
            for (int i = 0; i < 16; i++) begin
                s.idx  = rev ? tb_rev(i) : 4'(i);
                k      = int'(s.idx);
                s.re   = frame_re(f, k);
                s.im   = frame_im(f, k);
                s.last = (i == 15);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fft_valid = 1'b0;
        done      = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        fft_valid = 1'b0;
        done      = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) lane[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (a_valid !== 1'b0 || a_last !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid_last got %b%b want 00", a_valid, a_last);
        end
        total++;
        if (a_done !== 1'b0 || a_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_done_ovf got %b%b want 00", a_done, a_ovf);
        end
        total++;
        if (a_re !== 16'h0 || a_im !== 16'h0 || a_idx !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_data got re=%h im=%h idx=%0d want 0", a_re, a_im, a_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        do_reset();
        out_ready = 1'b1;
        send_frame(0, 1'b1, 1'b0);
        total++;
        if (a_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL single_latency got valid=%b want 1", a_valid);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im, a_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL single_sample got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             a_idx, a_re, a_im, a_last, e.idx, e.re, e.im, e.last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 16) begin
            bad++; $display("[TB] FAIL single_count got cycles=%0d left=%0d want 16/0", cyc, exp_q.size());
        end
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL single_idle got valid=%b want 0", a_valid);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0;
        send_frame(1, 1'b1, 1'b0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            out_ready = cyc[0];
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im, a_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL bp_sample got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             a_idx, a_re, a_im, a_last, e.idx, e.re, e.im, e.last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 32) begin
            bad++; $display("[TB] FAIL bp_count got cycles=%0d left=%0d want 32/0", cyc, exp_q.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_bitrev();
        do_reset();
        out_ready = 1'b1;
        send_frame(2, 1'b1, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (b_valid) begin
                e = exp_q[0];
                total++;
                if ({b_idx, b_re, b_im, b_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL bitrev_sample got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             b_idx, b_re, b_im, b_last, e.idx, e.re, e.im, e.last);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 16) begin
            bad++; $display("[TB] FAIL bitrev_count got cycles=%0d left=%0d want 16/0", cyc, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        send_frame(3, 1'b1, 1'b0);
        send_frame(4, 1'b1, 1'b0);
        total++;
        if (a_ovf !== 1'b0) begin
            bad++; $display("[TB] FAIL ovf_early got %b want 0", a_ovf);
        end
        send_frame(5, 1'b0, 1'b0);
        total++;
        if (a_ovf !== 1'b1) begin
            bad++; $display("[TB] FAIL ovf_set got %b want 1", a_ovf);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im, a_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL ovf_sample got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             a_idx, a_re, a_im, a_last, e.idx, e.re, e.im, e.last);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 32) begin
            bad++; $display("[TB] FAIL ovf_count got cycles=%0d left=%0d want 32/0", cyc, exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (a_valid !== 1'b0 || a_ovf !== 1'b1) begin
            bad++; $display("[TB] FAIL ovf_after got valid=%b ovf=%b want 0/1", a_valid, a_ovf);
        end
    endtask

    task automatic test_done();
        do_reset();
        out_ready = 1'b0;
        send_frame(6, 1'b1, 1'b0);
        send_frame(7, 1'b1, 1'b0);
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            done = (cyc == 20);
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im, a_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL done_sample got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             a_idx, a_re, a_im, a_last, e.idx, e.re, e.im, e.last);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        done = 1'b0;
        total++;
        if (a_done !== 1'b0 || cyc != 32) begin
            bad++; $display("[TB] FAIL done_early got out_done=%b cycles=%0d want 0/32", a_done, cyc);
        end
        @(posedge clk); #1;
        total++;
        if (a_done !== 1'b1) begin
            bad++; $display("[TB] FAIL done_rise got %b want 1", a_done);
        end
        // Only the real beat arrives before done: the half frame must block.
        do_reset();
        for (int i = 0; i < 16; i++) lane[i] = frame_re(8, i);
        fft_valid = 1'b1;
        @(posedge clk); #1;
        fft_valid = 1'b0;
        done      = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (a_done !== 1'b0 || a_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL done_partial got out_done=%b valid=%b want 0/0", a_done, a_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        out_ready = 1'b1;
        send_frame(9, 1'b1, 1'b0);
        cyc = 0;
        while (!(a_valid && a_idx == 4'd7) && cyc < 50) begin
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im} !== {e.idx, e.re, e.im}) begin
                    bad++;
                    $display("[TB] FAIL mid_sample got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                             a_idx, a_re, a_im, e.idx, e.re, e.im);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (cyc != 7) begin
            bad++; $display("[TB] FAIL mid_reach got cycles=%0d want 7", cyc);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (a_valid !== 1'b0 || a_idx !== 4'd0) begin
            bad++; $display("[TB] FAIL mid_reset got valid=%b idx=%0d want 0/0", a_valid, a_idx);
        end
        @(posedge clk); #1;
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_empty got valid=%b want 0", a_valid);
        end
        exp_q.delete();
        send_frame(10, 1'b1, 1'b0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            if (a_valid) begin
                e = exp_q[0];
                total++;
                if ({a_idx, a_re, a_im, a_last} !== {e.idx, e.re, e.im, e.last}) begin
                    bad++;
                    $display("[TB] FAIL mid_after got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                             a_idx, a_re, a_im, a_last, e.idx, e.re, e.im, e.last);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 16) begin
            bad++; $display("[TB] FAIL mid_count got cycles=%0d left=%0d want 16/0", cyc, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_bitrev();
        test_overflow();
        test_done();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_unpacker.md
# fft_frame_unpacker

Receive-side companion to the FFT core's 16-lane output port. Captures each FFT frame (one `fft_valid` beat of 16 real words followed by one beat of 16 imaginary words) into a two-bank buffer. Drains the frame as a serial complex stream over a valid/ready handshake. Sits between the FFT core and the downstream spectrum consumer, decoupling the FFT's burst output from a back-pressured serial sink.

## Interface
- `DW`, default 16: sample width (8 integer + 8 fraction, two's complement).
- `N`, default 16: points per frame; fixed at 16, i.e. the number of FFT output lanes.
- `BITREV`, default 0: 1 = emit bins in 4-bit bit-reversed lane order; 0 = natural lane order.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fft_valid`  in  1  one-cycle beat; 16 lanes valid this cycle.
- `done`  in  1  FFT core finished; level or pulse.
- `fft_d0` … `fft_d15`  in  DW each  lane k = bin k of the current beat.
- `out_valid`  out  1  serial sample available.
- `out_ready`  in  1  sink accepts sample.
- `out_re`  out  DW  real part of the current sample.
- `out_im`  out  DW  imaginary part of the current sample.
- `out_idx`  out  4  bin index of the current sample.
- `out_last`  out  1  high with the bin-15 sample, i.e. the last sample emitted for the frame.
- `out_done`  out  1  all frames drained after `done`; sticky.
- `overflow`  out  1  a frame was dropped; sticky.

## Operation
- **Beat phase toggle:** `phase` ∈ {RE, IM}; RE after reset.
  - `fft_valid` in RE writes the 16 lanes to `re[wr_bank]` and sets `phase`=IM.
  - `fft_valid` in IM writes the lanes to `im[wr_bank]`, sets `full[wr_bank]`, toggles `wr_bank`, and sets `phase`=RE.
- **Overflow:**
  - An RE beat arriving while `full[wr_bank]`=1 is a drop, and the matching IM beat is also dropped.
  - Implement this with a `drop` flag: it is set by the dropped RE beat and cleared by the next IM beat.
  - `phase` still toggles on dropped beats. `overflow` is set and stays high until `rst`.
- **Drain FSM:** states IDLE and SEND.
  - IDLE → SEND when `full[rd_bank]`=1; `rd_cnt` is cleared to 0.
  - In SEND, `out_valid`=1.
  - `out_idx` = `rd_cnt` (natural order) or `bitrev4(rd_cnt)` when `BITREV`=1. `out_re`/`out_im` = `re`/`im[rd_bank][out_idx]`.
  - On a handshake (`out_valid` && `out_ready`), `rd_cnt` increments.
  - A handshake at `rd_cnt`=15 clears `full[rd_bank]` and toggles `rd_bank`. The FSM then goes to SEND if the other bank is full, otherwise to IDLE.
  - `out_last` = SEND && `rd_cnt`==15.
- **Outputs hold:** while `out_valid`=1 and `out_ready`=0, all `out_*` signals stay stable.
- **Simultaneous events:**
  - Bank release and RE write to the same bank in the same cycle: the write is accepted and there is no overflow, because release takes priority in the full check.
  - IM capture into one bank concurrent with draining the other bank: both proceed.
- **done:**
  - `done` is latched into `done_seen`.
  - `out_done` = `done_seen` && both banks empty && `phase`=RE && FSM in IDLE.
  - An incomplete frame (RE received, IM not received) blocks `out_done`.
- **Arithmetic:** data passes through unmodified. No rounding or saturation.

## Timing
- **Reset values:** `out_valid`, `out_last`, `out_done`, `overflow`, `out_re`, `out_im`, and `out_idx` are all 0. Reset also forces:
  - `phase`=RE,
  - `wr_bank`=`rd_bank`=0,
  - `full`=00,
  - FSM in IDLE,
  - `done_seen`=0.
- **Reset mid-operation:** a reset during either drain or capture discards all buffered data. No output is emitted on the next cycle.
- **Latency:**
  - IM beat captured at edge T → `out_valid`=1 from T+1, presenting bin `out_idx` 0 (bitrev(0)=0).
  - At full throughput (`out_ready`=1), the frame drains in 16 cycles, T+1 … T+16.
  - When the next bank is full, back-to-back frames have no bubble.
- **Capacity:** the buffer holds two complete frames. The FFT core produces one frame per ≥16 input cycles, so a continuously-ready sink never overflows.
- **out_done:** registered; it asserts on the cycle after its conditions first hold.

## Structure
- Shared FFT package:
  - `DW`, `N`, lane count,
  - `typedef logic signed [DW-1:0] sample_t`,
  - `typedef enum {RE, IM} beat_phase_t`,
  - `typedef enum {IDLE, SEND} drain_state_t`,
  - function `bitrev4`.
- One sub-module: `fft_frame_bank`. It holds the 2×N×2 registers (`re`/`im` per bank), takes a write enable, bank select, and RE/IM select, and provides a combinational read port (bank, index).
- The top level holds the phase/drop/full/done logic and the drain FSM.

## Test plan
- **Single frame:** RE lanes = k×0x0100, IM lanes = −k×0x0010, `out_ready`=1 → 16 samples with `out_idx` 0..15, `out_re`=k×0x0100, `out_im`=0x10000−k×0x0010 (k=0 → 0x0000), `out_last` high only on idx 15.
- **Back-pressure:** toggle `out_ready` 1/0 each cycle → each sample held stable while `out_ready`=0; 16 handshakes over 32 cycles; no samples lost or duplicated.
- **BITREV=1:** same frame → `out_idx` sequence 0,8,4,12,2,…,15 with matching data.
- **Overflow:** `out_ready`=0, three frames sent → `overflow`=1 after the third RE beat. Raising `out_ready` → only frames 1 and 2 are emitted, then `out_valid`=0.
- **done:** two frames, then `done` pulse during frame 2's drain → `out_done` rises one cycle after frame 2's `out_last` handshake. If `done` arrives after only an RE beat → `out_done` stays 0.
- **Reset mid-drain:** `rst` for one cycle at `rd_cnt`=7 → next cycle `out_valid`=0 and `full`=00. A subsequent frame drains from idx 0.
